// File: rtl/mult32x32_pkg.sv
// ============================================================================
// Module   : mult32x32_pkg
// Brief    : Shared types and helpers for the 32x32 multiplier controller.
//            Used with or without MULT32X32_ZERO_SKIP_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mult32x32_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        STEP  = 2'd2,
        DONE  = 2'd3
    } mult_state_t;

    localparam int MULT_NUM_STEPS = 8;

    // Byte index of A plus two bytes per halfword of B gives the shift in bytes.
    function automatic logic [2:0] step_shift_sel(input logic [2:0] k);
        return {1'b0, k[1:0]} + {1'b0, k[2], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/mult32x32_skip_next.sv
// ============================================================================
// Module   : mult32x32_skip_next
// Brief    : Finds the next step index whose A byte is nonzero.
//            Compiled only when MULT32X32_ZERO_SKIP_EN is defined.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef MULT32X32_ZERO_SKIP_EN
module mult32x32_skip_next
    import mult32x32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [2:0]  k,
    input  logic        incl_cur,
    output logic [2:0]  next_k,
    output logic        none_left
);

    // Scanning downward leaves the lowest qualifying index in next_k.
    always_comb begin
        next_k    = 3'd0;
        none_left = 1'b1;
        for (int j = MULT_NUM_STEPS - 1; j >= 0; j--) begin
            if ((a[8*(j%4) +: 8] != 8'd0) &&
                ((j > int'(k)) || (incl_cur && (j == int'(k))))) begin
                next_k    = 3'(j);
                none_left = 1'b0;
            end
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/mult32x32_ctrl.sv
// ============================================================================
// Module   : mult32x32_ctrl
// Brief    : Control FSM sequencing eight 8x16 partial products of a 32x32
//            multiply. MULT32X32_ZERO_SKIP_EN skips steps whose A byte is zero.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mult32x32_ctrl
    import mult32x32_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    output logic [1:0]  a_sel,
    output logic        b_sel,
    output logic [2:0]  shift_sel,
    output logic        upd_prod,
    output logic        clr_prod,
    output logic        busy,
    output logic        done
);

    mult_state_t state_q, state_d;
    logic [2:0]  k_q, k_d;

`ifdef MULT32X32_ZERO_SKIP_EN
    logic       at_clear;
    logic [2:0] skip_k;
    logic       skip_none;

    assign at_clear = (state_q == CLEAR);

    // k_q is 0 in CLEAR, so including the current index finds the first step.
    mult32x32_skip_next u_skip_next (
        .a         (a),
        .k         (k_q),
        .incl_cur  (at_clear),
        .next_k    (skip_k),
        .none_left (skip_none)
    );
`else
    logic unused_a;
    assign unused_a = ^a;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            k_q     <= 3'd0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
        end
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        unique case (state_q)
            IDLE: begin
                k_d = 3'd0;
                if (start) state_d = CLEAR;
            end
            CLEAR: begin
`ifdef MULT32X32_ZERO_SKIP_EN
                if (skip_none) begin
                    state_d = DONE;
                    k_d     = 3'd0;
                end else begin
                    state_d = STEP;
                    k_d     = skip_k;
                end
`else
                state_d = STEP;
                k_d     = 3'd0;
`endif
            end
            STEP: begin
`ifdef MULT32X32_ZERO_SKIP_EN
                if (skip_none) begin
                    state_d = DONE;
                    k_d     = 3'd0;
                end else begin
                    k_d = skip_k;
                end
`else
                if (k_q == 3'(MULT_NUM_STEPS - 1)) begin
                    state_d = DONE;
                    k_d     = 3'd0;
                end else begin
                    k_d = k_q + 3'd1;
                end
`endif
            end
            DONE: begin
                state_d = IDLE;
                k_d     = 3'd0;
            end
            default: begin
                state_d = IDLE;
                k_d     = 3'd0;
            end
        endcase
    end

    // Pure Moore decode: start and a never reach the outputs combinationally.
    always_comb begin
        a_sel     = 2'd0;
        b_sel     = 1'b0;
        shift_sel = 3'd0;
        upd_prod  = 1'b0;
        clr_prod  = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            CLEAR: begin
                clr_prod = 1'b1;
                busy     = 1'b1;
            end
            STEP: begin
                upd_prod  = 1'b1;
                busy      = 1'b1;
                a_sel     = k_q[1:0];
                b_sel     = k_q[2];
                shift_sel = step_shift_sel(k_q);
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
                busy = 1'b0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: doc/mult32x32_ctrl.md
# mult32x32_ctrl

Control FSM for the 32x32 multiplier arithmetic unit. It accepts a `start` request and sequences the eight 8x16 partial products (four bytes of `a` times two halfwords of `b`) through the arithmetic unit's select, shift, clear and update controls. It reports `busy` while running and pulses `done` in the cycle the 64-bit product is final. It sits beside the arithmetic unit inside the multiplier top and is the only driver of that unit's control inputs.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  clock; all state changes on the rising edge
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a multiplication; sampled only in IDLE
- `a`  in  32  operand A; used only when `MULT32X32_ZERO_SKIP_EN` is defined; caller holds it stable from `start` to `done`
- `a_sel`  out  2  byte select for A
- `b_sel`  out  1  halfword select for B
- `shift_sel`  out  3  shifter select; shift = 8*`shift_sel` bits
- `upd_prod`  out  1  accumulate into the product register this cycle
- `clr_prod`  out  1  clear the product register this cycle
- `busy`  out  1  high in CLEAR and STEP
- `done`  out  1  one-cycle pulse; product valid in this cycle

## Operation
- States: IDLE, CLEAR, STEP, DONE. There is a 3-bit step index `k`.
- IDLE: all outputs are 0. `start`=1 moves to CLEAR.
- CLEAR: `clr_prod`=1 and `busy`=1 for exactly one cycle. Next state is STEP with `k`=0.
- STEP: `upd_prod`=1 and `busy`=1.
  - `a_sel`=`k[1:0]`, `b_sel`=`k[2]`, `shift_sel`=`a_sel` + 2*`b_sel` (range 0..5).
  - `k` increments each cycle. `k`=7 moves to DONE.
  - Resulting `shift_sel` sequence: 0,1,2,3,2,3,4,5.
- DONE: `done`=1 and `busy`=0 for one cycle, then IDLE unconditionally.
- `start` is ignored in CLEAR, STEP and DONE. There is no queueing, so a `start` held through DONE starts the next operation one cycle after IDLE is re-entered.
- Outputs are a Moore decode of the state and `k` registers. There is no combinational path from `start` or `a` to any output.
- Reset asserted at any time:
  - state goes to IDLE, `k`=0, all outputs 0 immediately (asynchronous).
  - An interrupted product is discarded. The next CLEAR re-zeroes the product register, because the arithmetic unit does not reset that register.
- Reset values: `a_sel`=0, `b_sel`=0, `shift_sel`=0, `upd_prod`=0, `clr_prod`=0, `busy`=0, `done`=0.

## Timing
- `start` sampled at edge E0. CLEAR occupies cycle 1. STEP occupies cycles 2–9. DONE occupies cycle 10.
- Fixed latency: 10 cycles from start edge to `done`. Throughput is one multiplication per 11 cycles when `start` is held high.
- The product register updates at the edge ending each STEP cycle. It holds the final value from the start of the DONE cycle until the next CLEAR.

## Configuration
- `MULT32X32_ZERO_SKIP_EN` defined:
  - STEP visits only indices whose byte `a[8*k[1:0]+:8]` is nonzero, in ascending `k` order.
  - CLEAR goes to the first valid `k`, or directly to DONE if `a`=0.
  - From STEP, the next state is the next valid `k`, or DONE if there is none.
  - Latency is 2 + 2*(number of nonzero bytes of `a`) cycles, so 2..10.
- Not defined: `a` is unused and the fixed 8-step sequence applies.

## Structure
- Shared package `mult32x32_pkg`:
  - state enum `mult_state_t` (IDLE, CLEAR, STEP, DONE)
  - constant `MULT_NUM_STEPS`=8
  - function mapping `k` to `shift_sel`
- Sub-module `mult32x32_skip_next`, compiled only under the macro. It is a combinational finder: given `a` and the current `k`, it returns the next valid index and a `none_left` flag.

## Test plan
- Integrate the controller with the arithmetic unit. Reset low for 2 cycles, then release. Check that all outputs are 0 and the state is IDLE before any `start`.
- `a`=0xFFFFFFFF, `b`=0xFFFFFFFF, `start` pulse:
  - `shift_sel` sequence is 0,1,2,3,2,3,4,5.
  - `done` rises at cycle 10.
  - `product`=0xFFFFFFFE00000001.
- `a`=3, `b`=5, with `start` held high for 25 cycles:
  - two operations complete, with `done` at cycles 10 and 21.
  - `product`=15 each time.
  - `start` is ignored while `busy`.
- Pull reset low during STEP cycle 5 of `a`=0xFFFFFFFF × `b`=2:
  - outputs go to 0 immediately.
  - a fresh `start` with `a`=7, `b`=6 yields `product`=42.
- With `MULT32X32_ZERO_SKIP_EN`:
  - `a`=0x00000003, `b`=0x00010001: STEP visits k=0 and k=4 only, `done` at cycle 4, `product`=0x30003.
  - `a`=0: `done` at cycle 2, `product`=0.
